// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit accumulator core: program counter, Start/Done handshake and write qualification.
// Optional watchdog enabled by defining PROG_SEQ_WATCHDOG_EN.
module prog_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CYC_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Branch,
    input  logic             Cond,
    input  logic             MemToReg,
    input  logic             Ack,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             ExecEn,
    output logic             Done,
    output logic [CYC_W-1:0] CycleCnt,
    output logic             Timeout
);

    localparam int unsigned STALL_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(LOAD_STALL);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(1);
    localparam logic [PC_W-1:0]    PC_START   = PC_W'(START_ADDR);
    localparam logic [CYC_W-1:0]   CYC_MAX    = '1;
    localparam bit                 HAS_STALL  = (LOAD_STALL > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [PC_W-1:0]    pc_d;
    logic [CYC_W-1:0]   cyc_d;
    logic [CYC_W-1:0]   cyc_inc;
    logic               done_d;
    logic               tmo_d;
    logic               wdog_hit;

    // Cycle counter saturates rather than wrapping
    assign cyc_inc = (CycleCnt == CYC_MAX) ? CycleCnt : CycleCnt + CYC_W'(1);

`ifdef PROG_SEQ_WATCHDOG_EN
    assign wdog_hit = (CycleCnt == CYC_MAX);
`else
    assign wdog_hit = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            stall_q  <= '0;
            ProgCtr  <= PC_START;
            CycleCnt <= '0;
            Done     <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            ProgCtr  <= pc_d;
            CycleCnt <= cyc_d;
            Done     <= done_d;
            Timeout  <= tmo_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        pc_d    = ProgCtr;
        cyc_d   = CycleCnt;
        tmo_d   = Timeout;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = PC_START;
                    cyc_d   = '0;
                    tmo_d   = 1'b0;
                end
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                if (wdog_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else if (Ack) begin
                    state_d = S_DONE;
                end else if (HAS_STALL && MemToReg) begin
                    state_d = S_STALL;
                    stall_d = STALL_LOAD;
                end else if (Branch && Cond) begin
                    pc_d = Target;
                end else begin
                    pc_d = ProgCtr + PC_W'(1);
                end
            end
            S_STALL: begin
                cyc_d = cyc_inc;
                if (wdog_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                    stall_d = '0;
                end else if (stall_q == STALL_LAST) begin
                    state_d = S_RUN;
                    stall_d = '0;
                    pc_d    = ProgCtr + PC_W'(1);
                end else begin
                    stall_d = stall_q - STALL_W'(1);
                end
            end
            S_DONE: begin
                if (!Start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    // Write qualification; the halt word and pending loads suppress writes
    always_comb begin
        ExecEn = 1'b0;
        case (state_q)
            S_RUN:   ExecEn = !Ack && !(HAS_STALL && MemToReg);
            S_STALL: ExecEn = (stall_q == STALL_LAST);
            default: ExecEn = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: the bench plays the decoder, pushes per-cycle expectations, a monitor compares.
module tb_prog_sequencer;

`ifdef PROG_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0;
    logic       Branch = 1'b0;
    logic       Cond = 1'b0;
    logic       MemToReg = 1'b0;
    logic       Ack = 1'b0;
    logic [9:0] Target = '0;
    logic [9:0] ProgCtr;
    logic       ExecEn;
    logic       Done;
    logic [3:0] CycleCnt;
    logic       Timeout;

    int checks = 0;
    int failures = 0;
    int step_no = 0;

    typedef struct {
        int idx;
        int pc;
        int en;
        int done;
        int cyc;
        int tmo;
    } exp_t;

    exp_t sb[$];

    prog_sequencer #(
        .PC_W(10),
        .START_ADDR(0),
        .LOAD_STALL(2),
        .CYC_W(4)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Start(Start),
        .Branch(Branch),
        .Cond(Cond),
        .MemToReg(MemToReg),
        .Ack(Ack),
        .Target(Target),
        .ProgCtr(ProgCtr),
        .ExecEn(ExecEn),
        .Done(Done),
        .CycleCnt(CycleCnt),
        .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int idx, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", nm, idx, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge
    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ProgCtr", e.idx, int'(ProgCtr), e.pc);
            chk("ExecEn", e.idx, int'(ExecEn), e.en);
            chk("Done", e.idx, int'(Done), e.done);
            chk("CycleCnt", e.idx, int'(CycleCnt), e.cyc);
            chk("Timeout", e.idx, int'(Timeout), e.tmo);
        end
    end

    // Drive one cycle of decoder/handshake inputs and queue the outputs expected in that cycle
    task automatic step(input bit rn, input bit st, input bit br, input bit cd, input bit ld,
                        input bit ak, input int tgt, input int pc, input bit en, input bit dn,
                        input int cy, input bit to);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset_n  = rn;
        Start    = st;
        Branch   = br;
        Cond     = cd;
        MemToReg = ld;
        Ack      = ak;
        Target   = 10'(tgt);
        e.idx  = step_no;
        e.pc   = pc;
        e.en   = int'(en);
        e.done = int'(dn);
        e.cyc  = cy;
        e.tmo  = int'(to);
        sb.push_back(e);
        step_no++;
    endtask

    initial begin
        //   rn st br cd ld ak tgt  pc en dn cyc to
        // Reset and idle
        step(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Three ADDs then the halt word
        step(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0,   2, 1, 0, 2, 0);
        step(1, 1, 0, 0, 0, 1, 0,   3, 0, 0, 3, 0);
        step(1, 1, 0, 0, 0, 0, 0,   3, 0, 1, 4, 0);
        step(1, 0, 0, 0, 0, 0, 0,   3, 0, 1, 4, 0);
        step(1, 0, 0, 0, 0, 0, 0,   3, 0, 0, 4, 0);
        // LOAD stall, BTRU not taken / taken, B to self, Ack with Branch
        step(1, 1, 0, 0, 0, 0, 0,   3, 0, 0, 4, 0);
        step(1, 0, 1, 1, 0, 0, 5,   0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0,   5, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0,   5, 0, 0, 2, 0);
        step(1, 0, 0, 0, 1, 0, 0,   5, 1, 0, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 4, 0);
        step(1, 0, 1, 0, 0, 0, 40,  7, 1, 0, 5, 0);
        step(1, 0, 1, 1, 0, 0, 7,   8, 1, 0, 6, 0);
        step(1, 0, 1, 1, 0, 0, 40,  7, 1, 0, 7, 0);
        step(1, 0, 1, 1, 0, 0, 40,  40, 1, 0, 8, 0);
        step(1, 0, 1, 1, 0, 0, 9,   40, 1, 0, 9, 0);
        step(1, 1, 1, 1, 0, 1, 0,   9, 0, 0, 10, 0);
        step(1, 1, 0, 0, 0, 0, 0,   9, 0, 1, 11, 0);
        step(1, 1, 0, 0, 0, 0, 0,   9, 0, 1, 11, 0);
        step(1, 0, 0, 0, 0, 0, 0,   9, 0, 1, 11, 0);
        step(1, 0, 0, 0, 0, 0, 0,   9, 0, 0, 11, 0);
        // Asynchronous reset in the last stall cycle
        step(1, 1, 0, 0, 0, 0, 0,   9, 0, 0, 11, 0);
        step(1, 0, 1, 1, 0, 0, 5,   0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0,   5, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0,   5, 0, 0, 2, 0);
        step(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // B looping on itself: counter saturation and optional watchdog
        step(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 12,  0, 1, 0, 0, 0);
        for (int k = 1; k < 16; k++) begin
            step(1, 0, 1, 1, 0, 0, 12, 12, 1, 0, k, 0);
        end
        step(1, 1, 1, 1, 0, 0, 12,  12, !WD, WD, 15, WD);
        step(1, 1, 1, 1, 0, 1, 12,  12, 0, WD, 15, WD);
        step(1, 0, 0, 0, 0, 0, 0,   12, 0, 1, 15, WD);
        step(1, 1, 0, 0, 0, 0, 0,   12, 0, 0, 15, WD);
        step(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);

        repeat (3) @(posedge Clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller for the 9-bit single-accumulator core.
- Owns the program counter and the Start/Done handshake with the testbench.
- Sequences fetch and execute using the decoder's Branch, MemToReg and Ack outputs.
- Produces ExecEn, which the top level ANDs into WriteR0, GenRegWrite and WriteMem. The decoder stays purely combinational; every architectural write is qualified here.

Parameters:
- PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
- START_ADDR, 0, PC value loaded on reset and on each Start.
- LOAD_STALL, 1, extra cycles a LOAD waits for synchronous data memory; 0 means no stall.
- CYC_W, 16, width of the cycle counter.

Ports:
- Clk  in  1  core clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  run request from the testbench; level-sensitive.
- Branch  in  1  decoder: current instruction is B or BTRU.
- Cond  in  1  branch condition; upstream ties it to 1 for B and to the flag for BTRU.
- MemToReg  in  1  decoder: current instruction is a LOAD.
- Ack  in  1  decoder: current instruction is the halt word 9'h1FF.
- Target  in  PC_W  branch target from the LUT.
- ProgCtr  out  PC_W  instruction ROM address.
- ExecEn  out  1  qualifies all register and memory writes this cycle.
- Done  out  1  program finished.
- CycleCnt  out  CYC_W  cycles spent executing the current run.
- Timeout  out  1  watchdog fired (see Optional Feature).

Behaviour:
- States: IDLE, RUN, STALL, DONE. Reset_n low forces, asynchronously: IDLE, ProgCtr=START_ADDR, CycleCnt=0, stall counter=0, Done=0, Timeout=0, ExecEn=0. This also applies mid-RUN or mid-STALL.
- IDLE:
  - ExecEn=0, Done=0.
  - Start=1 → RUN next cycle; ProgCtr loads START_ADDR; CycleCnt and Timeout clear.
- RUN: CycleCnt increments each cycle. Priority per cycle, highest first:
  1. Ack=1 → DONE; ProgCtr holds; ExecEn=0. The halt word has no side effects.
  2. MemToReg=1 and LOAD_STALL>0 → STALL; stall counter loads LOAD_STALL; ProgCtr holds; ExecEn=0.
  3. Branch=1 and Cond=1 → ProgCtr ← Target; ExecEn=1.
  4. Otherwise ProgCtr ← ProgCtr+1, modulo 2^PC_W (2^PC_W−1 wraps to 0); ExecEn=1.
  - Branch=1 with Cond=0 falls through to step 4.
  - MemToReg=1 with LOAD_STALL=0 executes in one cycle, ExecEn=1.
- STALL:
  - ProgCtr holds; the decoder inputs still reflect the LOAD; CycleCnt increments.
  - Stall counter >1: decrement; ExecEn=0.
  - Stall counter ==1: ExecEn=1 (the R0 write lands); ProgCtr ← ProgCtr+1; → RUN.
  - Total LOAD cost is 1+LOAD_STALL cycles.
- DONE:
  - Done=1, ExecEn=0; ProgCtr and CycleCnt hold.
  - Start=0 → IDLE; Done falls on the same edge.
  - Start held high keeps DONE. A fresh run needs Start low then high.
- Start changes during RUN or STALL are ignored.
- CycleCnt saturates at 2^CYC_W−1 and never wraps.
- All outputs are registered, except ExecEn, which is combinational from the state, stall counter and MemToReg.

Optional Feature:
- Macro: PROG_SEQ_WATCHDOG_EN.
- Defined: in RUN or STALL, CycleCnt reaching 2^CYC_W−1 forces DONE on the next edge with Timeout=1 and Done=1; ExecEn=0 from that edge. Timeout clears on the next Start or on reset.
- Undefined: Timeout is tied to 0; CycleCnt saturates and the run continues until Ack.

Test Plan:
- Reset, then Start=1 with ROM holding three ADDs then 9'h1FF → ProgCtr 0,1,2,3; ExecEn=1 for 3 cycles then 0; Done=1 one cycle after ProgCtr=3; CycleCnt=4.
- LOAD at PC 5 with LOAD_STALL=2 → ProgCtr holds 5 for 3 cycles; ExecEn pattern 0,0,1; ProgCtr=6 on the next edge.
- BTRU at PC 7, Target=40: Cond=0 → ProgCtr=8; Cond=1 → ProgCtr=40. B with Cond tied 1 → always 40.
- Ack and Branch both asserted at PC 9, Target=0 → DONE; ProgCtr stays 9; no write. Start held 1 keeps Done=1; Start=0 → IDLE, Done=0; Start=1 again → ProgCtr=START_ADDR, CycleCnt=0.
- Reset_n pulsed low mid-STALL → ProgCtr=START_ADDR, Done=0, ExecEn=0 immediately, without waiting for Clk.
- PROG_SEQ_WATCHDOG_EN with CYC_W=4 and a ROM looping B to itself → Timeout=1 and Done=1 after 15 counted cycles. Without the macro, no Done and CycleCnt holds at 15.
